// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch time counter: BCD digit width, digit
// limits and the default number of clk_en pulses per centisecond.
package stopwatch_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX_9 = 4'd9;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX_5 = 4'd5;
  localparam int CLK_EN_PER_CS_DEFAULT = 10;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the stopwatch: wraps to 0 after MAX and raises a
// combinational carry on the increment that causes the wrap.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = DIGIT_MAX_9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               clr,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry
);

  logic [DIGIT_W-1:0] digit_q;
  logic [DIGIT_W-1:0] digit_d;

  // Next digit value; anything at or above MAX wraps so the digit can never exceed its limit.
  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = {DIGIT_W{1'b0}};
    end else if (inc) begin
      digit_d = (digit_q >= MAX) ? {DIGIT_W{1'b0}} : (digit_q + 4'd1);
    end else begin
      digit_d = digit_q;
    end
  end

  // Digit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q <= {DIGIT_W{1'b0}};
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;
  assign carry = inc & (digit_q == MAX);

endmodule

// File: rtl/stopwatch_time_counter.sv
// Stopwatch time base: clk_en prescaler feeding a six-digit BCD MM:SS.cc counter.
// Optional lap-hold display freeze is enabled with `define STOPWATCH_LAP_HOLD_EN.
module stopwatch_time_counter
  import stopwatch_pkg::*;
#(
  parameter int CLK_EN_PER_CS = CLK_EN_PER_CS_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic               counting,
  input  logic               paused,
  input  logic               reset_timer,
`ifdef STOPWATCH_LAP_HOLD_EN
  input  logic               lap,
`endif
  output logic [DIGIT_W-1:0] cs_ones,
  output logic [DIGIT_W-1:0] cs_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] min_tens,
  output logic               tick_cs,
  output logic               overflow
);

  localparam int PS_W = (CLK_EN_PER_CS > 1) ? $clog2(CLK_EN_PER_CS) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_EN_PER_CS - 1);

  logic            adv;
  logic            ps_wrap;
  logic [PS_W-1:0] ps_q;
  logic [PS_W-1:0] ps_d;
  logic            tick_cs_q;
  logic            tick_cs_d;
  logic            overflow_q;
  logic            overflow_d;

  logic cs_inc;
  logic sec_inc;
  logic min_inc;
  logic cs_ones_carry;
  logic sec_ones_carry;
  logic min_ones_carry;
  logic min_tens_carry;

  logic [DIGIT_W-1:0] live_cs_ones;
  logic [DIGIT_W-1:0] live_cs_tens;
  logic [DIGIT_W-1:0] live_sec_ones;
  logic [DIGIT_W-1:0] live_sec_tens;
  logic [DIGIT_W-1:0] live_min_ones;
  logic [DIGIT_W-1:0] live_min_tens;

  assign adv     = clk_en & counting & ~paused & ~reset_timer;
  assign ps_wrap = (ps_q >= PS_LAST);
  assign cs_inc  = adv & ps_wrap;

  // Prescaler, tick and sticky overflow next state; reset_timer wins over everything.
  always_comb begin
    ps_d       = ps_q;
    tick_cs_d  = 1'b0;
    overflow_d = overflow_q;
    if (reset_timer) begin
      ps_d       = {PS_W{1'b0}};
      tick_cs_d  = 1'b0;
      overflow_d = 1'b0;
    end else begin
      if (adv) begin
        ps_d = ps_wrap ? {PS_W{1'b0}} : (ps_q + {{(PS_W-1){1'b0}}, 1'b1});
      end else begin
        ps_d = ps_q;
      end
      tick_cs_d  = cs_inc;
      overflow_d = overflow_q | min_tens_carry;
    end
  end

  // Prescaler phase survives pause/stop so a resumed run finishes the partial centisecond.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q       <= {PS_W{1'b0}};
      tick_cs_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      ps_q       <= ps_d;
      tick_cs_q  <= tick_cs_d;
      overflow_q <= overflow_d;
    end
  end

  bcd_digit_counter #(.MAX(DIGIT_MAX_9)) u_cs_ones (
    .clk(clk), .rst(rst), .inc(cs_inc), .clr(reset_timer),
    .digit(live_cs_ones), .carry(cs_ones_carry)
  );

  bcd_digit_counter #(.MAX(DIGIT_MAX_9)) u_cs_tens (
    .clk(clk), .rst(rst), .inc(cs_ones_carry), .clr(reset_timer),
    .digit(live_cs_tens), .carry(sec_inc)
  );

  bcd_digit_counter #(.MAX(DIGIT_MAX_9)) u_sec_ones (
    .clk(clk), .rst(rst), .inc(sec_inc), .clr(reset_timer),
    .digit(live_sec_ones), .carry(sec_ones_carry)
  );

  bcd_digit_counter #(.MAX(DIGIT_MAX_5)) u_sec_tens (
    .clk(clk), .rst(rst), .inc(sec_ones_carry), .clr(reset_timer),
    .digit(live_sec_tens), .carry(min_inc)
  );

  bcd_digit_counter #(.MAX(DIGIT_MAX_9)) u_min_ones (
    .clk(clk), .rst(rst), .inc(min_inc), .clr(reset_timer),
    .digit(live_min_ones), .carry(min_ones_carry)
  );

  bcd_digit_counter #(.MAX(DIGIT_MAX_5)) u_min_tens (
    .clk(clk), .rst(rst), .inc(min_ones_carry), .clr(reset_timer),
    .digit(live_min_tens), .carry(min_tens_carry)
  );

  assign tick_cs  = tick_cs_q;
  assign overflow = overflow_q;

`ifdef STOPWATCH_LAP_HOLD_EN
  logic                   hold_q;
  logic [6*DIGIT_W-1:0]   lap_q;
  logic [6*DIGIT_W-1:0]   live_bus;

  assign live_bus = {live_min_tens, live_min_ones, live_sec_tens,
                     live_sec_ones, live_cs_tens, live_cs_ones};

  // Lap toggles the hold state; the live time is snapshotted when hold engages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= 1'b0;
      lap_q  <= {(6*DIGIT_W){1'b0}};
    end else if (reset_timer) begin
      hold_q <= 1'b0;
      lap_q  <= {(6*DIGIT_W){1'b0}};
    end else if (lap) begin
      hold_q <= ~hold_q;
      lap_q  <= hold_q ? lap_q : live_bus;
    end else begin
      hold_q <= hold_q;
      lap_q  <= lap_q;
    end
  end

  assign {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones} =
         hold_q ? lap_q : live_bus;
`else
  assign cs_ones  = live_cs_ones;
  assign cs_tens  = live_cs_tens;
  assign sec_ones = live_sec_ones;
  assign sec_tens = live_sec_tens;
  assign min_ones = live_min_ones;
  assign min_tens = live_min_tens;
`endif

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Directed self-checking bench for stopwatch_time_counter (default CLK_EN_PER_CS = 10).
// Digits are compared as one BCD word MMSScc, e.g. 24'h015999 is 01:59.99.
module tb_stopwatch_time_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b0;
  logic       counting = 1'b0;
  logic       paused = 1'b0;
  logic       reset_timer = 1'b0;
`ifdef STOPWATCH_LAP_HOLD_EN
  logic       lap = 1'b0;
`endif
  logic [3:0] cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens;
  logic       tick_cs, overflow;
  logic [23:0] disp;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;

  stopwatch_time_counter dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .counting(counting),
    .paused(paused), .reset_timer(reset_timer),
`ifdef STOPWATCH_LAP_HOLD_EN
    .lap(lap),
`endif
    .cs_ones(cs_ones), .cs_tens(cs_tens), .sec_ones(sec_ones),
    .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .tick_cs(tick_cs), .overflow(overflow)
  );

  always #5 clk = ~clk;

  assign disp = {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones};

  always @(posedge clk) begin
    if (tick_cs) tick_cnt <= tick_cnt + 1;
  end

  // n isolated single-cycle clk_en pulses, each followed by an idle cycle
  task automatic en_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      clk_en = 1'b1;
      @(negedge clk);
      clk_en = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic clear_timer();
    reset_timer = 1'b1;
    @(negedge clk);
    reset_timer = 1'b0;
    @(negedge clk);
  endtask

  // Fast-forward the digits from 00:00.00 by forcing the increment inputs
  task automatic preload(input int mins, input int secs, input int cents);
    counting = 1'b0;
    if (mins > 0) begin
      force dut.min_inc = 1'b1;
      repeat (mins) @(posedge clk);
      #1 release dut.min_inc;
    end
    if (secs > 0) begin
      force dut.sec_inc = 1'b1;
      repeat (secs) @(posedge clk);
      #1 release dut.sec_inc;
    end
    if (cents > 0) begin
      force dut.cs_inc = 1'b1;
      repeat (cents) @(posedge clk);
      #1 release dut.cs_inc;
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    counting = 1'b1;
    clk_en = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (disp !== 24'h000000) begin
      errors++;
      $display("FAIL reset_digits: got %h expected %h", disp, 24'h000000);
    end
    checks++;
    if (tick_cs !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got tick=%b ovf=%b expected 0 0", tick_cs, overflow);
    end
    clk_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_first_cs();
    int t0;
    t0 = tick_cnt;
    counting = 1'b1;
    en_pulses(9);
    checks++;
    if (disp !== 24'h000000 || tick_cnt !== t0) begin
      errors++;
      $display("FAIL first_cs_early: got %h ticks=%0d expected 000000 ticks=%0d", disp, tick_cnt - t0, 0);
    end
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
    checks++;
    if (disp !== 24'h000001 || tick_cs !== 1'b1) begin
      errors++;
      $display("FAIL first_cs_inc: got %h tick=%b expected 000001 tick=1", disp, tick_cs);
    end
    @(negedge clk);
    checks++;
    if (tick_cs !== 1'b0 || tick_cnt - t0 !== 1) begin
      errors++;
      $display("FAIL first_cs_tick_once: got tick=%b count=%0d expected 0 1", tick_cs, tick_cnt - t0);
    end
  endtask

  task automatic test_minute_carry();
    clear_timer();
    preload(0, 59, 99);
    checks++;
    if (disp !== 24'h005999) begin
      errors++;
      $display("FAIL preload_59_99: got %h expected %h", disp, 24'h005999);
    end
    counting = 1'b1;
    en_pulses(10);
    checks++;
    if (disp !== 24'h010000 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL minute_carry: got %h ovf=%b expected 010000 ovf=0", disp, overflow);
    end
  endtask

  task automatic test_overflow();
    clear_timer();
    preload(59, 59, 99);
    checks++;
    if (disp !== 24'h595999 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL preload_max: got %h ovf=%b expected 595999 ovf=0", disp, overflow);
    end
    counting = 1'b1;
    en_pulses(10);
    checks++;
    if (disp !== 24'h000000 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL wrap: got %h ovf=%b expected 000000 ovf=1", disp, overflow);
    end
    clk_en = 1'b1;
    repeat (5000) @(negedge clk);
    clk_en = 1'b0;
    @(negedge clk);
    checks++;
    if (disp !== 24'h000500 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got %h ovf=%b expected 000500 ovf=1", disp, overflow);
    end
    reset_timer = 1'b1;
    @(negedge clk);
    reset_timer = 1'b0;
    checks++;
    if (disp !== 24'h000000 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: got %h ovf=%b expected 000000 ovf=0", disp, overflow);
    end
  endtask

  task automatic test_pause();
    int t0;
    clear_timer();
    counting = 1'b1;
    en_pulses(15);
    checks++;
    if (disp !== 24'h000001) begin
      errors++;
      $display("FAIL pause_pre: got %h expected %h", disp, 24'h000001);
    end
    t0 = tick_cnt;
    paused = 1'b1;
    clk_en = 1'b1;
    repeat (1000) @(negedge clk);
    clk_en = 1'b0;
    @(negedge clk);
    checks++;
    if (disp !== 24'h000001 || tick_cnt !== t0) begin
      errors++;
      $display("FAIL pause_hold: got %h ticks=%0d expected 000001 ticks=0", disp, tick_cnt - t0);
    end
    paused = 1'b0;
    en_pulses(4);
    checks++;
    if (disp !== 24'h000001) begin
      errors++;
      $display("FAIL resume_early: got %h expected %h", disp, 24'h000001);
    end
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
    checks++;
    if (disp !== 24'h000002 || tick_cs !== 1'b1) begin
      errors++;
      $display("FAIL resume_inc: got %h tick=%b expected 000002 tick=1", disp, tick_cs);
    end
    counting = 1'b0;
    clk_en = 1'b1;
    repeat (1000) @(negedge clk);
    clk_en = 1'b0;
    @(negedge clk);
    checks++;
    if (disp !== 24'h000002) begin
      errors++;
      $display("FAIL stopped_hold: got %h expected %h", disp, 24'h000002);
    end
  endtask

  task automatic test_reset_priority();
    clear_timer();
    counting = 1'b1;
    en_pulses(29);
    checks++;
    if (disp !== 24'h000002) begin
      errors++;
      $display("FAIL prio_pre: got %h expected %h", disp, 24'h000002);
    end
    clk_en = 1'b1;
    reset_timer = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
    reset_timer = 1'b0;
    checks++;
    if (disp !== 24'h000000 || tick_cs !== 1'b0) begin
      errors++;
      $display("FAIL prio_clear: got %h tick=%b expected 000000 tick=0", disp, tick_cs);
    end
    en_pulses(9);
    checks++;
    if (disp !== 24'h000000) begin
      errors++;
      $display("FAIL prio_ps_cleared: got %h expected %h", disp, 24'h000000);
    end
    en_pulses(1);
    checks++;
    if (disp !== 24'h000001) begin
      errors++;
      $display("FAIL prio_restart: got %h expected %h", disp, 24'h000001);
    end
  endtask

`ifdef STOPWATCH_LAP_HOLD_EN
  task automatic test_lap();
    int t0;
    clear_timer();
    preload(0, 1, 23);
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
    checks++;
    if (disp !== 24'h000123) begin
      errors++;
      $display("FAIL lap_capture: got %h expected %h", disp, 24'h000123);
    end
    t0 = tick_cnt;
    counting = 1'b1;
    clk_en = 1'b1;
    repeat (1000) @(negedge clk);
    clk_en = 1'b0;
    counting = 1'b0;
    @(negedge clk);
    checks++;
    if (disp !== 24'h000123 || tick_cnt - t0 !== 100) begin
      errors++;
      $display("FAIL lap_hold: got %h ticks=%0d expected 000123 ticks=100", disp, tick_cnt - t0);
    end
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
    checks++;
    if (disp !== 24'h000223) begin
      errors++;
      $display("FAIL lap_release: got %h expected %h", disp, 24'h000223);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_cs();
    test_minute_carry();
    test_overflow();
    test_pause();
    test_reset_priority();
`ifdef STOPWATCH_LAP_HOLD_EN
    test_lap();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_time_counter.md
STOPWATCH_TIME_COUNTER -- requirements
Module: stopwatch_time_counter

Interface
REQ-001 Parameter CLK_EN_PER_CS, default 10: clk_en pulses per centisecond (1 kHz clk_en gives 10 ms).
REQ-002 clk  input  1  system clock (50 MHz); single clock domain.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 clk_en  input  1  single-cycle time-base enable, ~1 kHz.
REQ-005 counting  input  1  high while the stopwatch control FSM is in RUN.
REQ-006 paused  input  1  high while the control FSM is in PAUSE.
REQ-007 reset_timer  input  1  level; clears the time while high.
REQ-008 cs_ones, cs_tens  output  4 each  BCD centiseconds.
REQ-009 sec_ones, sec_tens  output  4 each  BCD seconds; sec_tens is 0-5.
REQ-010 min_ones, min_tens  output  4 each  BCD minutes; min_tens is 0-5.
REQ-011 tick_cs  output  1  one-clk pulse on each centisecond increment.
REQ-012 overflow  output  1  sticky flag, set on wrap past 59:59.99.

Function
REQ-013 The module shall advance when adv = clk_en & counting & ~paused & ~reset_timer.
REQ-014 The prescaler shall count 0..CLK_EN_PER_CS-1 on adv cycles only.
REQ-015 When adv occurs with the prescaler at CLK_EN_PER_CS-1, the prescaler shall return to 0 and the time shall increment by 0.01 s at the same clk edge.
REQ-016 All outputs shall be registered, with digits visible one clk after the incrementing edge; tick_cs shall be high for exactly that one clk.
REQ-017 Digits shall cascade: cs_ones 9->0 carries into cs_tens, cs_tens 9->0 into sec_ones, sec_ones 9->0 into sec_tens, sec_tens 5->0 into min_ones, min_ones 9->0 into min_tens.
REQ-018 At 59:59.99, the next increment shall produce 00:00.00, set overflow, and continue counting.
REQ-019 While paused or counting is low, the prescaler and digits shall hold, and the prescaler phase shall not be cleared, so resume continues the partial centisecond.
REQ-020 reset_timer high shall clear the prescaler, all digits, tick_cs and overflow at the next clk edge regardless of clk_en, and shall take priority over counting.
REQ-021 overflow shall clear only on reset_timer or rst.
REQ-022 A digit shall never hold a value above 9, or above 5 for the tens-of-seconds and tens-of-minutes digits.

Reset
REQ-023 rst shall asynchronously force the prescaler and all digits to 0, tick_cs to 0 and overflow to 0.
REQ-024 After rst deasserts, counting shall start on the first adv cycle, with the first increment after exactly CLK_EN_PER_CS adv cycles.

Configuration
REQ-025 Macro STOPWATCH_LAP_HOLD_EN shall control the lap-hold feature.
REQ-026 With STOPWATCH_LAP_HOLD_EN defined, the module shall have an extra input lap (1 bit, single-clk pulse).
REQ-027 With the macro defined, each lap pulse shall toggle a hold state.
REQ-028 While hold is active, the digit outputs shall freeze at the value captured on the lap edge, and internal counting shall continue unaffected.
REQ-029 The second lap pulse shall release hold, and the outputs shall show the live time at the next clk.
REQ-030 With the macro defined, reset_timer and rst shall clear hold.
REQ-031 With the macro defined, tick_cs and overflow shall always reflect the live counter.
REQ-032 Without the macro, the lap port and hold logic shall be absent, and the outputs shall be the live counter.

Structure
REQ-033 Shared package stopwatch_pkg shall hold: BCD digit width (4), digit max constants (9, 5) and the default CLK_EN_PER_CS.
REQ-034 Sub-module bcd_digit_counter (parameter MAX; ports inc, clr, digit, carry) shall be instantiated six times, with carry combinational = inc & (digit == MAX).

Verification
REQ-035 rst, counting=1, 10 clk_en pulses -> cs_ones=1 and tick_cs pulses once, one clk after the 10th pulse.
REQ-036 Preload to 00:59.99 via adv, one more centisecond -> digits read 01:00.00 and overflow=0.
REQ-037 Run 59:59.99 plus one centisecond -> 00:00.00 with overflow=1; overflow stays 1 after a further 500 cs; reset_timer pulse -> all 0 and overflow=0.
REQ-038 Pause after 5 clk_en of a partial centisecond, hold 1000 clk_en, resume -> increment after exactly 5 more clk_en, and digits unchanged during the pause.
REQ-039 reset_timer asserted with counting=1 and clk_en=1 at prescaler=9 -> all digits 0, no tick_cs.
REQ-040 With STOPWATCH_LAP_HOLD_EN: lap at 00:01.23, run 100 cs -> outputs stay 00:01.23; second lap -> outputs show 00:02.23.
